// File: rtl/rrmuxn_pkg.sv
// Shared types and helpers for the rrmuxn round-robin streaming multiplexer.
package rrmuxn_pkg;

  typedef enum logic {ARB, LOCK} rrstate_t;

  // Next channel after v; wraps at n (N need not be a power of two).
  function automatic int unsigned mod_inc(input int unsigned v, input int unsigned n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rrmuxn_if.sv
// Stream bundle for rrmuxn: N requester channels in, one registered beat out.
interface rrmuxn_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
);
  logic [N-1:0]            InValid;
  logic [N-1:0]            InLast;
  logic [N-1:0][WIDTH-1:0] InData;
  logic [N-1:0]            InReady;
  logic                    OutValid;
  logic                    OutReady;
  logic [WIDTH-1:0]        OutData;
  logic                    OutLast;
  logic [SELW-1:0]         OutSel;

  // Requesters plus consumer side.
  modport master (
    output InValid, InLast, InData, OutReady,
    input  InReady, OutValid, OutData, OutLast, OutSel
  );

  // The multiplexer itself.
  modport slave (
    input  InValid, InLast, InData, OutReady,
    output InReady, OutValid, OutData, OutLast, OutSel
  );
endinterface

// File: rtl/rrmuxn_rrarbiter.sv
// Combinational arbiter: first requester at/after ptr (round-robin) or lowest index (fixed).
module rrarbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            fixed_pri,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] idx
);

  int unsigned cand;
  logic        found;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = fixed_pri ? k : int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/rrmuxn.sv
// N-channel streaming mux with round-robin/fixed arbitration, packet locking and
// a registered valid/ready output stage (one beat per cycle, one cycle latency).
module rrmuxn
  import rrmuxn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   FixedPri,
  rrmuxn_if.slave bus
);

  rrstate_t         state_q, state_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [SELW-1:0]  owner_q, owner_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [SELW-1:0]  out_sel_q;

  logic             load;
  logic [N-1:0]     arb_gnt;
  logic [SELW-1:0]  arb_idx;
  logic [N-1:0]     ready;
  logic [SELW-1:0]  sel;
  logic             xfer;

  rrarbiter #(.N(N), .SELW(SELW)) u_arb (
    .req       (bus.InValid),
    .ptr       (ptr_q),
    .fixed_pri (FixedPri),
    .gnt       (arb_gnt),
    .idx       (arb_idx)
  );

  assign load = ~out_valid_q | bus.OutReady;

  always_comb begin
    ready   = '0;
    sel     = arb_idx;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;

    // The owner is offered the slot even without InValid so a stalled
    // packet keeps its lock and shows up as an output bubble.
    if (!reset && load) begin
      if (state_q == LOCK) begin
        ready[owner_q] = 1'b1;
        sel            = owner_q;
      end else begin
        ready = arb_gnt;
      end
    end

    xfer = |(ready & bus.InValid);

    if (xfer) begin
      if (bus.InLast[sel]) begin
        state_d = ARB;
        if (!FixedPri) ptr_d = SELW'(mod_inc(int'(sel), N));
      end else begin
        state_d = LOCK;
        owner_d = sel;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      if (load) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_data_q <= bus.InData[sel];
          out_last_q <= bus.InLast[sel];
          out_sel_q  <= sel;
        end
      end
    end
  end

  assign bus.InReady  = ready;
  assign bus.OutValid = out_valid_q;
  assign bus.OutData  = out_data_q;
  assign bus.OutLast  = out_last_q;
  assign bus.OutSel   = out_sel_q;

endmodule
